// File: rtl/i2s_rx_frontend.sv
// Slave-mode Philips I2S receiver: oversampled in m_clk, 32-bit slots, MSB-aligned OUT_W output.
// Define I2S_RX_ERRCHK_EN to enable slot-length checking and the sticky frame_err flag.
module i2s_rx_frontend #(
   parameter int OUT_W       = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic             m_clk,
   input  logic             rst,
   input  logic             i2s_sck,
   input  logic             i2s_lrclk,
   input  logic             i2s_sdin,
   output logic [OUT_W-1:0] left_data,
   output logic [OUT_W-1:0] right_data,
   output logic             data_valid,
   output logic             locked,
   output logic             frame_err
);

   typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

   logic [SYNC_STAGES-1:0] sck_sync, lr_sync, sd_sync;
   logic        sck_hist, sck_rise;
   logic        rise_q, lr_q, sd_q;
   logic        lr_prev;
   logic [5:0]  cnt;
   logic [31:0] shreg, hold, closed;
   logic        lr_edge, latch_left, emit, frame_bad;
   state_t      state_q, state_d;

   assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_hist;

   // lrclk/sdin are captured from the same synchroniser depth as sck
   always_ff @(posedge m_clk or posedge rst) begin
      if (rst) begin
         sck_sync <= '0;
         lr_sync  <= '0;
         sd_sync  <= '0;
         sck_hist <= 1'b0;
         rise_q   <= 1'b0;
         lr_q     <= 1'b0;
         sd_q     <= 1'b0;
      end else begin
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], i2s_sck};
         lr_sync  <= {lr_sync[SYNC_STAGES-2:0], i2s_lrclk};
         sd_sync  <= {sd_sync[SYNC_STAGES-2:0], i2s_sdin};
         sck_hist <= sck_sync[SYNC_STAGES-1];
         rise_q   <= sck_rise;
         lr_q     <= lr_sync[SYNC_STAGES-1];
         sd_q     <= sd_sync[SYNC_STAGES-1];
      end
   end

   assign lr_edge = rise_q & (lr_q != lr_prev);

   // Slot word with the current bit inserted; also the closed word on an lr edge
   always_comb begin
      closed = shreg;
      if (!cnt[5])
         closed[5'd31 - cnt[4:0]] = sd_q;
   end

`ifdef I2S_RX_ERRCHK_EN
   logic bad_now, bad_q;
   assign bad_now   = lr_edge && (state_q != IDLE) && (cnt != 6'd31);
   assign frame_bad = bad_q | bad_now;
`else
   assign frame_bad = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      latch_left = 1'b0;
      emit       = 1'b0;
      case (state_q)
         IDLE:  if (lr_edge && lr_prev) state_d = LEFT;
         LEFT:  if (lr_edge) begin
                   latch_left = 1'b1;
                   state_d    = RIGHT;
                end
         RIGHT: if (lr_edge) begin
                   emit    = ~frame_bad;
                   state_d = LEFT;
                end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge m_clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge m_clk or posedge rst) begin
      if (rst) begin
         lr_prev    <= 1'b0;
         cnt        <= '0;
         shreg      <= '0;
         hold       <= '0;
         left_data  <= '0;
         right_data <= '0;
         data_valid <= 1'b0;
         locked     <= 1'b0;
      end else begin
         data_valid <= emit;
         if (rise_q) begin
            lr_prev <= lr_q;
            if (lr_edge) begin
               cnt   <= '0;
               shreg <= '0;
            end else if (!cnt[5]) begin
               shreg <= closed;
               cnt   <= cnt + 6'd1;
            end
         end
         if (latch_left) hold <= closed;
         if (emit) begin
            left_data  <= hold[31 -: OUT_W];
            right_data <= closed[31 -: OUT_W];
            locked     <= 1'b1;
         end
      end
   end

`ifdef I2S_RX_ERRCHK_EN
   // Bad-frame marker lives until the right slot closes; frame_err is sticky
   always_ff @(posedge m_clk or posedge rst) begin
      if (rst) begin
         bad_q     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (lr_edge && state_q == RIGHT) bad_q <= 1'b0;
         else if (bad_now)                bad_q <= 1'b1;
         if (bad_now) frame_err <= 1'b1;
      end
   end
`else
   assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// Directed bench for i2s_rx_frontend: bit-level I2S source, scoreboard of expected frames.
module tb_i2s_rx_frontend;

   logic m_clk = 1'b0;
   logic rst = 1'b0;
   logic sck, lr, sd;
   logic [23:0] l24, r24;
   logic [31:0] l32, r32;
   logic dv24, dv32, lk24, lk32, fe24, fe32;

   always #5 m_clk = ~m_clk;

   i2s_rx_frontend #(.OUT_W(24), .SYNC_STAGES(2)) dut (
      .m_clk(m_clk), .rst(rst), .i2s_sck(sck), .i2s_lrclk(lr), .i2s_sdin(sd),
      .left_data(l24), .right_data(r24), .data_valid(dv24), .locked(lk24), .frame_err(fe24));

   i2s_rx_frontend #(.OUT_W(32), .SYNC_STAGES(2)) dut32 (
      .m_clk(m_clk), .rst(rst), .i2s_sck(sck), .i2s_lrclk(lr), .i2s_sdin(sd),
      .left_data(l32), .right_data(r32), .data_valid(dv32), .locked(lk32), .frame_err(fe32));

   typedef struct {logic [31:0] l; logic [31:0] r;} exp_t;
   exp_t sb[$];

   int pass_cnt = 0, total_cnt = 0;
   int cyc = 0, last_rise = 0, prev_dv = 0, dv_cnt = 0;
   bit prev_valid = 0, cad_on = 0, tail_sent = 0, synced = 0, prev_lsb = 0;

   always @(posedge m_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One BCLK period: data/ws change with the falling edge, 8+8 m_clk phases
   task automatic drive_bit(input bit l, input bit d);
      sck = 1'b0; lr = l; sd = d;
      repeat (8) @(negedge m_clk);
      sck = 1'b1;
      last_rise = cyc;
      repeat (8) @(negedge m_clk);
   endtask

   // Bit 0 of a ws period carries the previous word's LSB, then w[31], w[30], ...
   task automatic send_range(input bit l, input logic [31:0] w, input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         drive_bit(l, (i == 0) ? prev_lsb : w[32-i]);
   endtask

   task automatic send_period(input bit l, input logic [31:0] w, input int n);
      send_range(l, w, tail_sent ? 1 : 0, n-1);
      tail_sent = 0;
      prev_lsb  = w[0];
   endtask

   task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw);
      send_period(1'b0, lw, 32);
      send_period(1'b1, rw, 32);
      if (synced) sb.push_back('{lw, rw});
      synced = 1;
   endtask

   task automatic send_tail();
      drive_bit(1'b0, prev_lsb);
      tail_sent = 1;
   endtask

   // Output monitor: pops the scoreboard on every data_valid
   initial begin
      exp_t e;
      bit dv_prev;
      dv_prev = 0;
      forever begin
         @(negedge m_clk);
         if (dv24 === 1'b1) begin
            dv_cnt++;
            check("dv_back_to_back", dv_prev, 0);
            check("dv32_align", dv32, 1);
            check("dv_latency", cyc - last_rise, 4);
            if (cad_on && prev_valid)
               check("dv_spacing_in_window", (cyc - prev_dv >= 1008) && (cyc - prev_dv <= 1040), 1);
            prev_dv = cyc;
            prev_valid = 1;
            check("sb_has_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("left24", l24, e.l[31:8]);
               check("right24", r24, e.r[31:8]);
               check("left32", l32, e.l);
               check("right32", r32, e.r);
               check("locked_on_dv", lk24, 1);
            end
         end
         dv_prev = dv24;
      end
   end

   initial begin
      int n0;
      rst = 1'b1; sck = 1'b0; lr = 1'b0; sd = 1'b0;
      repeat (5) @(negedge m_clk);
      check("rst_left", l24, 0);
      check("rst_right", r24, 0);
      check("rst_dv", dv24, 0);
      check("rst_locked", lk24, 0);
      check("rst_frame_err", fe24, 0);
      check("rst_left32", l32, 0);
      rst = 1'b0;
      repeat (3) @(negedge m_clk);

      // Normal frames: first frame only synchronises
      send_frame(32'h12345678, 32'hFEDCBA98);
      check("locked_after_f1", lk24, 0);
      send_frame(32'h12345678, 32'hFEDCBA98);
      check("no_dv_before_lsb", dv_cnt, 0);
      send_tail();
      check("one_dv_first_frame", dv_cnt, 1);
      check("locked_set", lk24, 1);

      // Sign extremes
      send_frame(32'h80000000, 32'hFFFFFFFF);
      send_tail();
      check("sign_dv", dv_cnt, 2);

      // Cadence: 8 distinct back-to-back frames
      prev_valid = 0; cad_on = 1; n0 = dv_cnt;
      for (int k = 0; k < 8; k++)
         send_frame(32'h01234567 + 32'h11111111 * k, 32'hA5A5_0000 ^ (32'h0000_1357 * (k + 1)));
      send_tail();
      cad_on = 0;
      check("cadence_count", dv_cnt - n0, 8);

      // Reset halfway through a left slot
      send_range(1'b0, 32'hDEADBEEF, 1, 15);
      rst = 1'b1;
      repeat (4) @(negedge m_clk);
      check("midrst_left", l24, 0);
      check("midrst_right", r24, 0);
      check("midrst_locked", lk24, 0);
      check("midrst_dv", dv24, 0);
      rst = 1'b0;
      synced = 0; tail_sent = 0;
      send_range(1'b0, 32'hDEADBEEF, 16, 31);
      prev_lsb = 1'b1;
      send_period(1'b1, 32'hCAFEF00D, 32);
      synced = 1;
      n0 = dv_cnt;
      send_frame(32'h13579BDF, 32'h2468ACE0);
      check("no_dv_after_rst", dv_cnt - n0, 0);
      send_tail();
      check("dv_after_rst", dv_cnt - n0, 1);

      // Short (31-bit) left slot, then a good frame
      send_period(1'b0, 32'hFFFFFFFF, 31);
      send_period(1'b1, 32'h00001234, 32);
`ifndef I2S_RX_ERRCHK_EN
      sb.push_back('{32'hFFFFFFFE, 32'h00001234});
`endif
      send_frame(32'h0F0F0F0F, 32'h70F0F0F0);
      send_tail();
`ifdef I2S_RX_ERRCHK_EN
      check("frame_err_sticky", fe24, 1);
`else
      check("frame_err_off", fe24, 0);
`endif
      check("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/i2s_rx_frontend.md
# i2s_rx_frontend

Slave-mode I2S receiver at the input of the DSP datapath inside `Dig_top`. It oversamples the externally driven `i2s_sck`, `i2s_lrclk` and `i2s_sdin` in the `m_clk` domain. It deserialises standard Philips I2S frames: 64 BCLK per frame, 32-bit slots, one-bit delay after each LRCLK edge, MSB first. It presents left/right samples MSB-aligned to `OUT_W` bits, together with a one-cycle `data_valid` strobe for the downstream filter chain.

## Interface
- `OUT_W`, 24: output sample width. Range 1..32; the top `OUT_W` bits of each 32-bit slot are kept.
- `SYNC_STAGES`, 2: synchroniser flops on each I2S input. Minimum 2.

Clocking and reset:
- One clock; reset is asynchronous and active-high.
- `m_clk` input, 1: system clock, 49.152 MHz.
- `rst` input, 1: asynchronous active-high reset; all state and outputs are cleared while high.

Ports:
- `i2s_sck` input, 1: I2S bit clock, 3.072 MHz nominal, asynchronous to `m_clk`.
- `i2s_lrclk` input, 1: word select; 0 = left, 1 = right.
- `i2s_sdin` input, 1: serial data; the source changes it after the falling edge of `i2s_sck`.
- `left_data` output, `OUT_W`: last complete left sample, two's complement.
- `right_data` output, `OUT_W`: last complete right sample, two's complement.
- `data_valid` output, 1: one-cycle pulse; `left_data`/`right_data` updated this cycle.
- `locked` output, 1: high once the first complete frame has been delivered.
- `frame_err` output, 1: sticky slot-length error. Tied 0 unless `I2S_RX_ERRCHK_EN` is defined.

## Operation
- Input conditioning:
  - Each input passes through `SYNC_STAGES` flops, plus one history flop on `sck`.
  - `sck_rise` = synchronised `sck` is 1 and its history is 0.
  - `lrclk` and `sdin` are used only on `sck_rise`, from the same synchronised stage as `sck`.
- On each `sck_rise`, sample bit `b` and `lr`, and compare `lr` with `lr_prev`, the `lr` sampled at the previous `sck_rise`.
  - If `lr != lr_prev`: `b` is the LSB of the channel `lr_prev`. The slot closes and the bit counter `cnt` resets to 0 for the new channel.
  - Otherwise: `b` is written to slot bit `31-cnt` of the current channel while `cnt < 32`; `cnt` saturates at 32. Bits past 32 are ignored.
- Slot shift register: cleared at slot start, so missing trailing bits read 0.
- FSM states:
  - `IDLE` (reset state): ignore data and wait for the first `lr` 1→0 transition, then go to `LEFT`. The closing bit is discarded.
  - `LEFT`: accumulate the left slot. On `lr` 0→1, latch the left slot into a hold register and go to `RIGHT`.
  - `RIGHT`: accumulate the right slot. On `lr` 1→0, complete the right slot, then:
    - update `left_data` = hold[31:32-OUT_W] and `right_data` = right[31:32-OUT_W];
    - pulse `data_valid` and set `locked`;
    - go to `LEFT`.
- First output frame: the first full left+right pair after leaving `IDLE`. A partial frame is never emitted.
- `data_valid` is never asserted on two consecutive cycles.
- Reset mid-frame: everything clears and the FSM returns to `IDLE`. The next frame boundary resynchronises; no stale data is emitted.

## Timing
- Reset values: `left_data` = 0, `right_data` = 0, `data_valid` = 0, `locked` = 0, `frame_err` = 0.
- Latency, `i2s_sck` pin rise → detected `sck_rise`: `SYNC_STAGES`+1 `m_clk` cycles.
- `data_valid` and the output update occur 1 cycle after the `sck_rise` that samples the right LSB, i.e. `SYNC_STAGES`+2 cycles after that pin edge (4 with defaults).
- Input requirement: `i2s_sck` high and low phases must each be ≥ `SYNC_STAGES`+1 `m_clk` periods; nominal is 8.
- Output hold: `left_data`/`right_data` are stable between `data_valid` pulses, for one frame period (1024 `m_clk` cycles nominal).

## Configuration
- `I2S_RX_ERRCHK_EN` defined:
  - At each slot close, if the slot length (`cnt`+1) ≠ 32, set `frame_err`. It clears only on `rst`.
  - The frame containing the bad slot produces no `data_valid`.
  - The FSM continues normally from the same edge.
- Not defined:
  - `frame_err` is constant 0 and slot length is unchecked.
  - Short slots are zero-padded in the LSBs; long slots are truncated to 32 bits.
  - Every completed frame is emitted.

## Test plan
- Normal frame: after reset, send frames L=32'h12345678, R=32'hFEDCBA98 (`OUT_W`=24).
  - Frame 1 (incomplete sync) → no `data_valid`.
  - Next full frame → `data_valid` pulses once; `left_data`=24'h123456, `right_data`=24'hFEDCBA; `locked`=1.
- Sign handling: L=32'h80000000, R=32'hFFFFFFFF → `left_data`=24'h800000, `right_data`=24'hFFFFFF.
- Pulse cadence: stream 8 frames with distinct values.
  - Exactly 8 `data_valid` pulses (after the first), spaced 1024±16 cycles.
  - Each output equals the previous frame's input.
  - Pulse occurs 4 cycles after the pin `i2s_sck` rise of the right LSB.
- Reset mid-frame: assert `rst` halfway through a left slot, release it, then continue streaming.
  - Outputs are 0 during reset.
  - First `data_valid` appears only after a complete new frame, with correct values.
- Short slot with `I2S_RX_ERRCHK_EN`: send a 31-bit left slot → `frame_err`=1 and no `data_valid` for that frame. The following good frame is emitted; `frame_err` stays 1.
- Short slot without the macro: the same stimulus with L=32'hFFFFFFFF → `data_valid` fires; `left_data` equals the 31 received bits MSB-aligned with LSB 0 (24'hFFFFFF for `OUT_W`=24; check with `OUT_W`=32 → 32'hFFFFFFFE); `frame_err`=0.
